lfsr_deserializer: RTL and testbench
====================================

Name: lfsr_deserializer

Overview:
- Downstream consumer of the LFSR serial output stage. That stage emits one bit per cycle on OUT, qualified by Valid, LSB first.
- This block samples the qualified serial stream and rebuilds W-bit words in original bit order.
- Completed words go to a one-deep holding register with a valid/ready handshake toward the next stage (e.g. a sequence checker or FIFO).
- Reports dropped words (overrun) and, optionally, parity errors.

Parameters:
- W, 8, word width in bits; must match the upstream LFSR width; legal range 2..32.
- CW, 6, width of the bit_count output; must satisfy 2^CW > W.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  serial bit qualifier (connects to upstream Valid)
- in_bit  input  1  serial data bit (connects to upstream OUT)
- clear  input  1  synchronous flush of frame state, holding register and flags
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  W  assembled word; bit i = i-th received data bit
- out_valid  output  1  out_data holds an unconsumed word
- overrun  output  1  sticky; a completed word was dropped
- bit_count  output  CW  data bits collected in the current frame (0..W-1)
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without the macro

Behaviour:
- Reset (reset=0, async): shift register=0, bit_count=0, FSM=S_DATA, out_data=0, out_valid=0, overrun=0, parity_err=0. Reset is honoured at any point mid-frame; partial bits are discarded.
- Sampling: a bit is taken only on a rising edge with in_valid=1. Cycles with in_valid=0 are gaps and leave all state unchanged.
- Shift order: the received bit enters at index bit_count. The first bit lands in position 0, so LSB-first serial input reconstructs the word unchanged.
- FSM states:
  - S_DATA: on each sampled bit, bit_count increments.
  - On the W-th sampled bit, the word is complete (the incoming bit is included), bit_count returns to 0, and the block attempts delivery.
  - With DESER_PARITY_EN defined, the FSM moves to S_PARITY instead of delivering.
  - S_PARITY: waits for the next sampled bit, performs the parity check, attempts delivery, then returns to S_DATA.
- Delivery latency: out_valid rises in the cycle after the sampling edge of the final bit of the frame.
- Handshake: a transfer occurs when out_valid=1 and out_ready=1 on the same edge. out_valid and out_data stay stable until that transfer. out_ready is ignored while out_valid=0.
- Holding register empty at delivery: load the word, set out_valid=1.
- Holding register full, transfer on the same edge as delivery: the new word loads and out_valid stays 1. No bubble, no overrun.
- Holding register full, no transfer on that edge: the new word is dropped, the held word is kept, and overrun is set.
- overrun stays set until reset or clear.
- clear=1: same effect as reset, but synchronous. clear has priority over a simultaneous sampled bit and over a simultaneous transfer.
- bit_count reflects the registered count, i.e. bits collected before the current edge.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each frame is W data bits followed by one even-parity bit. The XOR of the data bits and the parity bit must be 0.
  - A mismatch pulses parity_err for exactly one cycle, coincident with the cycle out_valid would rise.
  - The word is still delivered (or counted as overrun) regardless of parity.
- Undefined:
  - Frames are W bits and there is no S_PARITY state.
  - parity_err is held at constant 0.

Test Plan:
- Basic word, macro off: bits 1,0,1,0,0,1,0,1 with in_valid=1, out_ready=1 -> one cycle after the 8th bit, out_valid=1 and out_data=8'hA5; out_valid drops after the transfer edge.
- Gaps: same 0xA5 bits with in_valid toggling 1,0 every cycle -> out_data=8'hA5; bit_count steps 0..7 only on valid cycles.
- Overrun: out_ready=0, send 0x3C then 0xFF -> out_data stays 8'h3C and overrun=1; raise out_ready -> 0x3C transfers, out_valid=0, overrun remains 1 until clear.
- Back-to-back delivery: hold 0x11, send 0x22 with out_ready=1 on the completion edge -> out_data becomes 8'h22 with no gap in out_valid and overrun=0.
- Reset mid-frame: send 4 bits, pulse reset low -> all outputs 0; then send 0x5A -> out_data=8'h5A (no stale bits).
- Parity, macro on: send 0xA5 + parity 0 -> parity_err stays 0; send 0xA5 + parity 1 -> parity_err high for one cycle and out_data=8'hA5.

Source files
------------

// File: rtl/lfsr_deserializer_if.sv
// Serial-in / word-out bundle for lfsr_deserializer; master is the stimulus side, slave is the deserializer.
interface lfsr_deserializer_if #(
  parameter int W  = 8,
  parameter int CW = 6
);
  logic          in_valid;
  logic          in_bit;
  logic          clear;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          overrun;
  logic [CW-1:0] bit_count;
  logic          parity_err;

  modport master (
    output in_valid, in_bit, clear, out_ready,
    input  out_data, out_valid, overrun, bit_count, parity_err
  );

  modport slave (
    input  in_valid, in_bit, clear, out_ready,
    output out_data, out_valid, overrun, bit_count, parity_err
  );
endinterface

// File: rtl/lfsr_deserializer.sv
// Rebuilds LSB-first W-bit words from a qualified serial stream; out_valid rises 1 cycle after the last frame bit.
// One-deep holding register with valid/ready; a word completing while full and not draining is dropped (sticky overrun). DESER_PARITY_EN adds an even-parity bit per frame.
module lfsr_deserializer #(
  parameter int W  = 8,
  parameter int CW = 6
) (
  input  logic                clock,
  input  logic                reset,
  lfsr_deserializer_if.slave  bus
);

`ifdef DESER_PARITY_EN
  typedef enum logic [0:0] {S_DATA, S_PARITY} state_t;
`else
  typedef enum logic [0:0] {S_DATA} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic          ovr_q, ovr_d;
  logic          perr_q, perr_d;
  logic [W-1:0]  ins;
  logic [W-1:0]  word;
  logic          deliver;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    perr_d  = 1'b0;
    deliver = 1'b0;

    // Incoming bit lands at the current count so the first bit is bit 0.
    ins = shift_q;
    for (int i = 0; i < W; i++) begin
      if (cnt_q == CW'(i)) ins[i] = bus.in_bit;
    end
    word = ins;

    if (vld_q && bus.out_ready) vld_d = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        S_DATA: begin
          shift_d = ins;
          if (cnt_q == CW'(W - 1)) begin
            cnt_d = '0;
`ifdef DESER_PARITY_EN
            state_d = S_PARITY;
`else
            deliver = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef DESER_PARITY_EN
        S_PARITY: begin
          word    = shift_q;
          perr_d  = ^{shift_q, bus.in_bit};
          deliver = 1'b1;
          state_d = S_DATA;
        end
`endif
        default: ;
      endcase
    end

    // vld_d already reflects a same-edge transfer, so a draining register accepts the new word.
    if (deliver) begin
      if (!vld_d) begin
        data_d = word;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (bus.clear) begin
      state_d = S_DATA;
      shift_d = '0;
      cnt_d   = '0;
      data_d  = '0;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_DATA;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.overrun   = ovr_q;
  assign bus.bit_count = cnt_q;
`ifdef DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_deserializer.sv
// Randomized and directed bench for lfsr_deserializer against a frame-level reference model.
module tb_lfsr_deserializer;
  localparam int W  = 8;
  localparam int CW = 6;
`ifdef DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lfsr_deserializer_if #(.W(W), .CW(CW)) bus ();

  lfsr_deserializer #(.W(W), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: the bits of the current frame in arrival order plus the holding register.
  bit          frame[$];
  int unsigned exp_data = 0;
  bit          exp_vld  = 0;
  bit          exp_ovr  = 0;
  bit          exp_perr = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame.delete();
      exp_data = 0; exp_vld = 0; exp_ovr = 0; exp_perr = 0;
    end else begin
      exp_perr = 0;
      if (bus.clear) begin
        frame.delete();
        exp_data = 0; exp_vld = 0; exp_ovr = 0;
      end else begin
        if (exp_vld && bus.out_ready) exp_vld = 0;
        if (bus.in_valid) begin
          frame.push_back(bus.in_bit);
          if (frame.size() == FRAME) begin
            int unsigned w;
            int          ones;
            w = 0; ones = 0;
            for (int i = 0; i < W; i++) w += frame[i] * (1 << i);
            for (int i = 0; i < FRAME; i++) ones += frame[i];
`ifdef DESER_PARITY_EN
            exp_perr = (ones % 2) != 0;
`endif
            if (!exp_vld) begin
              exp_data = w;
              exp_vld  = 1;
            end else begin
              exp_ovr = 1;
            end
            frame.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    int unsigned ec;
    ec = (frame.size() >= W) ? 0 : frame.size();
    chk("out_valid",  bus.out_valid,  exp_vld);
    chk("out_data",   bus.out_data,   exp_data);
    chk("overrun",    bus.overrun,    exp_ovr);
    chk("bit_count",  bus.bit_count,  ec);
    chk("parity_err", bus.parity_err, exp_perr);
  end

  task automatic step(input logic v, input logic b, input logic r, input logic c = 1'b0);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.out_ready = r;
    bus.clear     = c;
    @(posedge clock);
    #1;
  endtask

  // Sends one frame; the parity bit (if any) is even parity, inverted when bad=1.
  task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last, input logic bad = 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      logic b;
      b = (i < W) ? w[i] : (^w ^ bad);
      step(1'b1, b, (i == FRAME - 1) ? r_last : r);
    end
  endtask

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;
    bus.in_valid = 0; bus.in_bit = 0; bus.out_ready = 0; bus.clear = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data,  0);
    chk("rst_count", bus.bit_count, 0);
    reset = 1'b1;

    // Basic word
    send_word(8'hA5, 1'b1, 1'b1);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_data",  bus.out_data,  8'hA5);
    step(0, 0, 1);
    chk("basic_drop", bus.out_valid, 0);

    // Gaps between bits
    for (int i = 0; i < FRAME; i++) begin
      logic b;
      b = (i < W) ? a5[i] : ^a5;
      step(1, b, 1);
      chk("gap_count_v", bus.bit_count, (i + 1 >= W) ? 0 : i + 1);
      if (i < FRAME - 1) begin
        step(0, 0, 1);
        chk("gap_count_g", bus.bit_count, (i + 1 >= W) ? 0 : i + 1);
      end
    end
    chk("gap_data", bus.out_data, 8'hA5);
    step(0, 0, 1);

    // Overrun
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("ovr_data",  bus.out_data, 8'h3C);
    chk("ovr_flag",  bus.overrun,  1);
    step(0, 0, 1);
    chk("ovr_drain", bus.out_valid, 0);
    chk("ovr_stick", bus.overrun,   1);
    step(0, 0, 0, 1);
    chk("ovr_clear", bus.overrun,   0);

    // Back-to-back delivery
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    chk("b2b_data",  bus.out_data,  8'h22);
    chk("b2b_valid", bus.out_valid, 1);
    chk("b2b_ovr",   bus.overrun,   0);
    step(0, 0, 1);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    reset = 1'b0;
    #2;
    chk("mid_rst_count", bus.bit_count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data",  bus.out_data,  0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send_word(8'h5A, 1'b0, 1'b0);
    chk("mid_rst_5a", bus.out_data, 8'h5A);
    step(0, 0, 1);

`ifdef DESER_PARITY_EN
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("par_ok", bus.parity_err, 0);
    send_word(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("par_bad",      bus.parity_err, 1);
    chk("par_bad_data", bus.out_data,   8'hA5);
    step(0, 0, 1);
    chk("par_pulse_end", bus.parity_err, 0);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
